// File: rtl/scariv_brtag_alloc_ctrl_if.sv
// Branch-tag allocator bus: dispatch allocation handshake, commit/flush frees,
// snapshot-RAM restore strobe and occupancy status.
interface scariv_brtag_alloc_ctrl_if #(
    parameter int ENTRY_SIZE  = 8,
    parameter int ALLOC_WIDTH = 2,
    parameter int PERF_W      = 32
);
    localparam int TAG_W = $clog2(ENTRY_SIZE);

    logic                   i_alloc_valid;
    logic [ALLOC_WIDTH-1:0] i_alloc_req;
    logic                   o_alloc_ready;
    logic [TAG_W-1:0]       o_alloc_brtag [ALLOC_WIDTH];

    logic                   i_cmt_valid;
    logic [TAG_W-1:0]       i_cmt_brtag;

    logic                   i_flush_valid;
    logic [TAG_W-1:0]       i_flush_brtag;

    logic                   o_restore_valid;
    logic [TAG_W-1:0]       o_restore_brtag;

    logic [ENTRY_SIZE-1:0]  o_busy;
    logic                   o_empty;
    logic                   o_full;
    logic [PERF_W-1:0]      o_stall_cycles;

    // Dispatch / branch-resolution side.
    modport master (
        output i_alloc_valid, i_alloc_req,
        output i_cmt_valid, i_cmt_brtag,
        output i_flush_valid, i_flush_brtag,
        input  o_alloc_ready, o_alloc_brtag,
        input  o_restore_valid, o_restore_brtag,
        input  o_busy, o_empty, o_full, o_stall_cycles
    );

    // Allocator side.
    modport slave (
        input  i_alloc_valid, i_alloc_req,
        input  i_cmt_valid, i_cmt_brtag,
        input  i_flush_valid, i_flush_brtag,
        output o_alloc_ready, o_alloc_brtag,
        output o_restore_valid, o_restore_brtag,
        output o_busy, o_empty, o_full, o_stall_cycles
    );
endinterface

// File: rtl/scariv_brtag_alloc_ctrl.sv
// Branch-tag allocator and snapshot restore sequencer for the rename snapshot RAMs.
// Optional stall counter enabled by defining SCARIV_BRTAG_ALLOC_PERF_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | normal operation, allocation allowed
// RESTORE | one-cycle snapshot read strobe for the captured flush tag
module scariv_brtag_alloc_ctrl #(
    parameter int ENTRY_SIZE  = 8,
    parameter int ALLOC_WIDTH = 2,
    parameter int PERF_W      = 32
) (
    input logic                   i_clk,
    input logic                   i_reset,
    scariv_brtag_alloc_ctrl_if.slave bif
);
    localparam int TAG_W = $clog2(ENTRY_SIZE);
    localparam int CNT_W = $clog2(ALLOC_WIDTH + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ENTRY_SIZE-1:0] busy_q, busy_d;
    logic [TAG_W-1:0]      tail_q, tail_d;
    logic [TAG_W-1:0]      restore_tag_q, restore_tag_d;

    logic [CNT_W-1:0]      alloc_cnt;
    logic                  alloc_ready;
    logic                  grant;
    logic [TAG_W-1:0]      flush_span;
    logic [ENTRY_SIZE-1:0] flush_mask;

    always_comb begin
        alloc_cnt = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            alloc_cnt = alloc_cnt + CNT_W'(bif.i_alloc_req[k]);
        end
    end

    // Strict in-order allocation: any busy slot in the tail window blocks the group.
    always_comb begin
        logic [TAG_W-1:0] slot;
        alloc_ready = (state_q == IDLE) && !bif.i_flush_valid;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            slot = tail_q + TAG_W'(k);
            if ((CNT_W'(k) < alloc_cnt) && busy_q[slot]) begin
                alloc_ready = 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            bif.o_alloc_brtag[k] = tail_q + TAG_W'(k);
        end
    end

    // Flushed range is the ring segment [flush_tag, tail). A zero span means the
    // flushed branch is the oldest of a full ring, so every slot is younger.
    always_comb begin
        logic [TAG_W-1:0] off;
        flush_span = tail_q - bif.i_flush_brtag;
        flush_mask = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            off = TAG_W'(i) - bif.i_flush_brtag;
            if ((flush_span == '0) || (off < flush_span)) begin
                flush_mask[i] = 1'b1;
            end
        end
    end

    assign grant = bif.i_alloc_valid && alloc_ready;

    always_comb begin
        logic [TAG_W-1:0] slot;
        state_d       = state_q;
        busy_d        = busy_q;
        tail_d        = tail_q;
        restore_tag_d = restore_tag_q;
        slot          = '0;

        case (state_q)
            IDLE:    state_d = bif.i_flush_valid ? RESTORE : IDLE;
            RESTORE: state_d = bif.i_flush_valid ? RESTORE : IDLE;
            default: state_d = IDLE;
        endcase

        if (bif.i_cmt_valid) begin
            busy_d[bif.i_cmt_brtag] = 1'b0;
        end

        if (bif.i_flush_valid) begin
            busy_d        = busy_d & ~flush_mask;
            tail_d        = bif.i_flush_brtag + TAG_W'(1);
            restore_tag_d = bif.i_flush_brtag;
        end else if (grant) begin
            for (int k = 0; k < ALLOC_WIDTH; k++) begin
                slot = tail_q + TAG_W'(k);
                if (CNT_W'(k) < alloc_cnt) begin
                    busy_d[slot] = 1'b1;
                end
            end
            tail_d = tail_q + TAG_W'(alloc_cnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            busy_q        <= '0;
            tail_q        <= '0;
            restore_tag_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            tail_q        <= tail_d;
            restore_tag_q <= restore_tag_d;
        end
    end

    assign bif.o_alloc_ready   = alloc_ready;
    assign bif.o_restore_valid = (state_q == RESTORE);
    assign bif.o_restore_brtag = restore_tag_q;
    assign bif.o_busy          = busy_q;
    assign bif.o_empty         = ~|busy_q;
    assign bif.o_full          = &busy_q;

`ifdef SCARIV_BRTAG_ALLOC_PERF_EN
    logic [PERF_W-1:0] stall_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_q <= '0;
        end else if (bif.i_alloc_valid && !alloc_ready && !(&stall_q)) begin
            stall_q <= stall_q + PERF_W'(1);
        end
    end

    assign bif.o_stall_cycles = stall_q;
`else
    assign bif.o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_scariv_brtag_alloc_ctrl.sv
// Directed scoreboard bench for scariv_brtag_alloc_ctrl (8 slots, 2 lanes).
module tb_scariv_brtag_alloc_ctrl;
    localparam int ENTRY_SIZE  = 8;
    localparam int ALLOC_WIDTH = 2;
    localparam int PERF_W      = 32;
    localparam int TAG_W       = 3;

    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    scariv_brtag_alloc_ctrl_if #(
        .ENTRY_SIZE (ENTRY_SIZE),
        .ALLOC_WIDTH(ALLOC_WIDTH),
        .PERF_W     (PERF_W)
    ) bif ();

    scariv_brtag_alloc_ctrl #(
        .ENTRY_SIZE (ENTRY_SIZE),
        .ALLOC_WIDTH(ALLOC_WIDTH),
        .PERF_W     (PERF_W)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bif    (bif)
    );

    int total = 0;
    int bad   = 0;

    logic [TAG_W-1:0] tag_q [$];
    logic [TAG_W-1:0] rst_q [$];
    logic [TAG_W-1:0] tail_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.i_alloc_valid = 1'b0;
        bif.i_alloc_req   = '0;
        bif.i_cmt_valid   = 1'b0;
        bif.i_cmt_brtag   = '0;
        bif.i_flush_valid = 1'b0;
        bif.i_flush_brtag = '0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        repeat (2) next_cycle();
        i_reset = 1'b0;
        tail_m  = '0;
        tag_q.delete();
        rst_q.delete();
    endtask

    task automatic alloc(input logic [ALLOC_WIDTH-1:0] req, input logic exp_grant, input string tag);
        int n;
        logic [TAG_W-1:0] e;
        n = 0;
        for (int k = 0; k < ALLOC_WIDTH; k++) n += int'(req[k]);
        bif.i_alloc_valid = 1'b1;
        bif.i_alloc_req   = req;
        #1;
        check({tag, ".ready"}, 64'(bif.o_alloc_ready), 64'(exp_grant));
        if (exp_grant) begin
            for (int k = 0; k < n; k++) tag_q.push_back(tail_m + TAG_W'(k));
            for (int k = 0; k < n; k++) begin
                e = tag_q.pop_front();
                check({tag, ".brtag"}, 64'(bif.o_alloc_brtag[k]), 64'(e));
            end
            tail_m = tail_m + TAG_W'(n);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic commit(input logic [TAG_W-1:0] t);
        bif.i_cmt_valid = 1'b1;
        bif.i_cmt_brtag = t;
        next_cycle();
        idle_inputs();
    endtask

    // Other inputs set by the caller stay applied during the flush cycle.
    task automatic flush(input logic [TAG_W-1:0] t, input string tag);
        bif.i_flush_valid = 1'b1;
        bif.i_flush_brtag = t;
        rst_q.push_back(t);
        #1;
        check({tag, ".ready"}, 64'(bif.o_alloc_ready), 64'd0);
        tail_m = t + TAG_W'(1);
        next_cycle();
        idle_inputs();
    endtask

    task automatic check_restore(input string tag);
        logic [TAG_W-1:0] e;
        check({tag, ".valid"}, 64'(bif.o_restore_valid), 64'd1);
        if (rst_q.size() == 0) begin
            check({tag, ".queue"}, 64'(rst_q.size()), 64'd1);
        end else begin
            e = rst_q.pop_front();
            check({tag, ".brtag"}, 64'(bif.o_restore_brtag), 64'(e));
        end
    endtask

    initial begin
        logic [PERF_W-1:0] exp_stall;

        do_reset();
        check("rst.busy",    64'(bif.o_busy), 64'h0);
        check("rst.empty",   64'(bif.o_empty), 64'd1);
        check("rst.full",    64'(bif.o_full), 64'd0);
        check("rst.ready",   64'(bif.o_alloc_ready), 64'd1);
        check("rst.rvalid",  64'(bif.o_restore_valid), 64'd0);
        check("rst.rbrtag",  64'(bif.o_restore_brtag), 64'd0);
        check("rst.stall",   64'(bif.o_stall_cycles), 64'd0);

        // Fill the ring two tags per cycle.
        repeat (4) alloc(2'b11, 1'b1, "t1.fill");
        check("t1.full", 64'(bif.o_full), 64'd1);
        check("t1.busy", 64'(bif.o_busy), 64'hff);
        alloc(2'b01, 1'b0, "t1.blocked");

        // Freeing a non-tail slot must not unblock allocation.
        commit(3'd3);
        check("t2.busy3", 64'(bif.o_busy), 64'hf7);
        alloc(2'b01, 1'b0, "t2.tail_busy");
        commit(3'd0);
        check("t2.busy0", 64'(bif.o_busy), 64'hf6);
        alloc(2'b01, 1'b1, "t2.regrant");
        check("t2.busy_re", 64'(bif.o_busy), 64'hf7);

        // Flush frees the flushed tag and all younger ones.
        do_reset();
        repeat (3) alloc(2'b11, 1'b1, "t3.fill");
        check("t3.busy_pre", 64'(bif.o_busy), 64'h3f);
        flush(3'd2, "t3.flush");
        check("t3.busy", 64'(bif.o_busy), 64'h03);
        check_restore("t3.restore");
        alloc(2'b01, 1'b0, "t3.n1");
        check("t3.rvalid_off", 64'(bif.o_restore_valid), 64'd0);
        alloc(2'b01, 1'b1, "t3.n2");
        check("t3.busy_post", 64'(bif.o_busy), 64'h0b);

        // Flush with simultaneous alloc and commit.
        bif.i_alloc_valid = 1'b1;
        bif.i_alloc_req   = 2'b11;
        bif.i_cmt_valid   = 1'b1;
        bif.i_cmt_brtag   = 3'd0;
        flush(3'd1, "t4.flush_alloc");
        check("t4.busy", 64'(bif.o_busy), 64'h00);
        check_restore("t4.restore");
        next_cycle();
        alloc(2'b11, 1'b1, "t4.after");
        check("t4.busy_post", 64'(bif.o_busy), 64'h0c);

        // Back-to-back flushes across the ring wrap.
        commit(3'd2);
        commit(3'd3);
        alloc(2'b11, 1'b1, "t5.a45");
        commit(3'd4);
        alloc(2'b11, 1'b1, "t5.a67");
        alloc(2'b01, 1'b1, "t5.a0");
        check("t5.busy_pre", 64'(bif.o_busy), 64'he1);
        flush(3'd6, "t5.flush6");
        check("t5.busy6", 64'(bif.o_busy), 64'h20);
        check_restore("t5.r6");
        flush(3'd5, "t5.flush5");
        check_restore("t5.r5");
        check("t5.busy5", 64'(bif.o_busy), 64'h00);
        next_cycle();
        check("t5.rvalid_off", 64'(bif.o_restore_valid), 64'd0);
        alloc(2'b01, 1'b1, "t5.tail");

        // Reset arriving while RESTORE is active.
        flush(3'd6, "t6.flush");
        check_restore("t6.restore");
        i_reset = 1'b1;
        next_cycle();
        i_reset = 1'b0;
        tail_m  = '0;
        check("t6.rvalid", 64'(bif.o_restore_valid), 64'd0);
        check("t6.rbrtag", 64'(bif.o_restore_brtag), 64'd0);
        check("t6.empty",  64'(bif.o_empty), 64'd1);
        alloc(2'b11, 1'b1, "t6.after");

        // Stall counter over ten blocked cycles.
        do_reset();
        repeat (4) alloc(2'b11, 1'b1, "t7.fill");
        bif.i_alloc_valid = 1'b1;
        bif.i_alloc_req   = 2'b01;
        repeat (10) next_cycle();
        idle_inputs();
`ifdef SCARIV_BRTAG_ALLOC_PERF_EN
        exp_stall = PERF_W'(10);
`else
        exp_stall = '0;
`endif
        check("t7.stall", 64'(bif.o_stall_cycles), 64'(exp_stall));
        next_cycle();
        check("t7.stall_hold", 64'(bif.o_stall_cycles), 64'(exp_stall));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
